shift_deser: RTL
================

Name: shift_deser

Overview:
Serial-in, parallel-out receiver: the far end of the team's parallel-load shift register used as a serialiser. It collects one bit per qualified clock, supports LSB-first order (transmitter shifting right) and MSB-first order (transmitter shifting left), and presents each completed word on a valid/ready output port. It sits between a serial link and word-wide consumer logic, with a one-word output buffer and overflow detection.

Parameters:
WIDTH, 4, word width in bits (>= 2); bit counter is clog2(WIDTH) bits wide.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset; highest priority
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is sampled on this edge
sync  input  1  with bit_valid: this bit is bit 0 of a new word; any partial word is discarded
msb_first  input  1  bit order; sampled only on the first bit of each word
clr  input  1  synchronous clear of the partial word and ovf; output buffer untouched
dout  output  WIDTH  assembled word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
bit_cnt  output  clog2(WIDTH)  bits collected in the current partial word
ovf  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst=1 at the edge): the shift register, bit_cnt, the latched order bit, dout, dout_valid and ovf all go to 0. rst overrides every other input.
- Priority below rst: clr, then sync/bit_valid. If clr=1 while bit_valid=1, the bit is ignored, bit_cnt=0 and ovf=0. dout and dout_valid are unchanged, and a handshake on that edge still completes.
- The first bit of a word is taken when bit_cnt=0, or on any bit with sync=1. On that bit, msb_first is latched into ord_q for the whole word.
- Per accepted bit:
  - ord_q=0 (LSB first): sh <= {bit_in, sh[WIDTH-1:1]}.
  - ord_q=1 (MSB first): sh <= {sh[WIDTH-2:0], bit_in}.
  - For the first bit, the shift uses the freshly sampled msb_first.
- bit_cnt increments on each accepted bit. sync=1 forces bit_cnt to 1 after the edge, and the accepted bit becomes bit 0 of the new word.
- bit_valid=0: the shift register and bit_cnt hold, so gaps between bits are allowed.
- Word completion: the accepted bit is the WIDTH-th bit (bit_cnt=WIDTH-1 before the edge, sync=0).
  - bit_cnt wraps to 0.
  - The completed word (including this bit) is the candidate for the output buffer.
- Output buffer (one entry):
  - Completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 on the same edge: dout <= word, dout_valid=1. No overflow.
  - Completion with dout_valid=1 and dout_ready=0: the word is dropped, ovf <= 1, and the buffered dout is preserved.
  - Handshake with no completion: dout_valid <= 0. dout keeps its last value.
- Latency: dout_valid rises on the edge that samples the last bit, so it is visible in the following cycle.
- Throughput: one word per WIDTH bits with no stall when dout_ready is held at 1.
- ovf stays set until clr or rst.
- rst or clr mid-word discards the partial bits. The next accepted bit is bit 0 of a new word.

Test Plan (WIDTH=4):
1. LSB-first: msb_first=0, dout_ready=1, bits 1,0,1,1 on consecutive edges.
   -> dout=4'b1101, dout_valid=1 for exactly one cycle after the 4th edge, bit_cnt=0.
2. MSB-first: msb_first=1, same bits.
   -> dout=4'b1011.
   Also toggle msb_first after the first bit -> result unchanged.
3. Backpressure: dout_ready=0.
   - Word A=1,1,0,0 (LSB-first) gives dout=4'b0011, dout_valid=1.
   - Word B=1,1,1,1 then completes -> ovf=1 and dout stays 4'b0011.
   - Raise dout_ready -> A consumed, dout_valid=0.
   - Pulse clr -> ovf=0.
4. Simultaneous events: dout_valid=1 with dout_ready=1 on the same edge as the 4th bit of the next word.
   -> new word loaded, dout_valid stays 1, ovf=0.
   Bits sent with idle cycles between them -> same word as without gaps.
5. Resync and reset:
   - After 2 bits, an edge with sync=1 and bit_in=1 -> bit_cnt=1.
   - 3 further bits 0,0,1 (LSB-first) -> dout=4'b1001.
   - Separately, rst after 3 bits -> all outputs 0; the next 4 bits form a fresh word.

Source files
------------

// File: rtl/shift_deser_if.sv
// Serial-link and word-output signals of the shift_deser receiver.
// The slave modport is the receiver side; master is the link/consumer side.
interface shift_deser_if #(
    parameter int WIDTH = 4
) ();
    localparam int CW = $clog2(WIDTH);

    logic             bit_in;
    logic             bit_valid;
    logic             sync;
    logic             msb_first;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_cnt;
    logic             ovf;

    modport slave (
        input  bit_in, bit_valid, sync, msb_first, clr, dout_ready,
        output dout, dout_valid, bit_cnt, ovf
    );

    modport master (
        output bit_in, bit_valid, sync, msb_first, clr, dout_ready,
        input  dout, dout_valid, bit_cnt, ovf
    );
endinterface

// File: rtl/shift_deser.sv
// Serial-in, parallel-out receiver with selectable bit order, a one-word
// valid/ready output buffer and a sticky overflow flag for dropped words.
module shift_deser #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_deser_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             ord_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             ovf_q;

    logic             first;
    logic             ord_eff;
    logic             complete;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_nxt;

    // The first bit of a word uses the live msb_first; later bits use the latched order.
    assign first    = (cnt_q == '0) || bus.sync;
    assign ord_eff  = first ? bus.msb_first : ord_q;
    assign shifted  = ord_eff ? {sh_q[WIDTH-2:0], bus.bit_in}
                              : {bus.bit_in, sh_q[WIDTH-1:1]};
    assign complete = bus.bit_valid && !bus.clr && !bus.sync && (cnt_q == LAST);
    assign cnt_nxt  = complete ? '0 : (bus.sync ? CW'(1) : cnt_q + CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q         <= '0;
            cnt_q        <= '0;
            ord_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (bus.clr) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (bus.bit_valid) begin
                sh_q  <= shifted;
                cnt_q <= cnt_nxt;
                if (first) ord_q <= bus.msb_first;
            end

            // A completed word may replace a word consumed on the same edge.
            if (complete) begin
                if (!dout_valid_q || bus.dout_ready) begin
                    dout_q       <= shifted;
                    dout_valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.ovf        = ovf_q;
endmodule
